// File: rtl/risac_lsu_pkg.sv
// Shared types and lane helpers for the RV32 load/store unit.
package risac_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

  function automatic logic [3:0] lsu_byteenable(input lsu_size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Stores replicate the datum across every lane it could occupy.
  function automatic logic [31:0] lsu_wdata(input lsu_size_e size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/risac_lsu_align.sv
// Load extract: selects the addressed lanes of a read word and sign/zero-extends them.
module risac_lsu_align
  import risac_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  lsu_size_e   size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [31:0]        shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = shifted[15:0];
    case (size)
      SZ_BYTE: result = is_unsigned ? {24'h0, shifted[7:0]} : 32'(byte_s);
      SZ_HALF: result = is_unsigned ? {16'h0, shifted[15:0]} : 32'(half_s);
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/risac_lsu_avalon.sv
// RV32 load/store unit driving a single-port Avalon-MM data memory.
// Define RISAC_LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of masking them.
module risac_lsu_avalon
  import risac_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata
);

  lsu_state_e  state_q, state_d;
  lsu_size_e   size_in;
  logic        accept, fault, issue, below_base;
  logic [31:0] rel_addr;
  logic [1:0]  off_in;
  logic [1:0]  wait_cnt;

  lsu_size_e   size_p1;
  logic [1:0]  off_p1;
  logic        unsigned_p1;
  logic        we_p1;
  logic [31:0] rdata_p2;
  logic [31:0] load_val;

  assign accept  = req_valid & req_ready;
  assign size_in = lsu_size_e'(req_size);
  assign issue   = accept & ~fault;

  // Borrow out of the subtraction flags addresses below the window.
  assign {below_base, rel_addr} = {1'b0, req_addr} - {1'b0, BASE_ADDR};

  always_comb begin
    fault = (req_size == 2'd3) || below_base || ((rel_addr >> (ADDR_W + 2)) != 32'd0);
`ifdef RISAC_LSU_MISALIGN_TRAP_EN
    if (size_in == SZ_HALF && req_addr[0])
      fault = 1'b1;
    if (size_in == SZ_WORD && req_addr[1:0] != 2'b00)
      fault = 1'b1;
`endif
    case (size_in)
      SZ_BYTE: off_in = req_addr[1:0];
      SZ_HALF: off_in = {req_addr[1], 1'b0};
      default: off_in = 2'b00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = fault ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_d = we_p1 ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (wait_cnt == 2'd0) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // p0 -> p1: control and bus strobes, all registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
      we_p1          <= 1'b0;
      wait_cnt       <= 2'd0;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_byteenable <= 4'b0000;
      avm_writedata  <= 32'd0;
    end else begin
      state_q        <= state_d;
      req_ready      <= (state_d == ST_IDLE);
      rsp_valid      <= (state_d == ST_RESP);
      rsp_err        <= accept & fault;
      if (accept)
        we_p1 <= req_we;
      if (state_q == ST_ISSUE)
        wait_cnt <= 2'(READ_LATENCY - 1);
      else if (state_q == ST_WAIT)
        wait_cnt <= wait_cnt - 2'd1;
      avm_chipselect <= issue;
      avm_write      <= issue & req_we;
      avm_address    <= issue ? rel_addr[ADDR_W+1:2] : '0;
      avm_byteenable <= issue ? lsu_byteenable(size_in, off_in) : 4'b0000;
      avm_writedata  <= (issue & req_we) ? lsu_wdata(size_in, req_wdata) : 32'd0;
    end
  end

  // p1 -> p2: request attributes and captured read word (cleared so stores/faults return 0)
  always_ff @(posedge clk) begin
    if (accept) begin
      size_p1     <= size_in;
      off_p1      <= off_in;
      unsigned_p1 <= req_unsigned;
      rdata_p2    <= 32'd0;
    end else if (state_q == ST_WAIT && wait_cnt == 2'd0) begin
      rdata_p2 <= avm_readdata;
    end
  end

  risac_lsu_align u_align (
    .rdata       (rdata_p2),
    .size        (size_p1),
    .off         (off_p1),
    .is_unsigned (unsigned_p1),
    .result      (load_val)
  );

  assign rsp_rdata = rsp_valid ? load_val : 32'd0;

endmodule

// File: tb/tb_risac_lsu_avalon.sv
// Directed bench for risac_lsu_avalon with a byte-level reference model and memory slave.
module tb_risac_lsu_avalon;

  localparam int          ADDR_W = 10;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          RL     = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [31:0]       req_addr = 32'd0;
  logic [1:0]        req_size = 2'd0;
  logic              req_unsigned = 1'b0;
  logic [31:0]       req_wdata = 32'd0;
  logic              req_ready, rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect, avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;

  risac_lsu_avalon #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable), .avm_chipselect(avm_chipselect),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory slave with one cycle of read latency
  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    if (avm_chipselect && !avm_write)
      avm_readdata <= {mem[{avm_address, 2'd3}], mem[{avm_address, 2'd2}],
                       mem[{avm_address, 2'd1}], mem[{avm_address, 2'd0}]};
    if (avm_chipselect && avm_write)
      for (int i = 0; i < 4; i++)
        if (avm_byteenable[i]) mem[{avm_address, i[1:0]}] <= avm_writedata[8*i +: 8];
  end

  // Reference model state
  logic [7:0]        ref_mem [0:4095];
  bit                chk_en = 1'b0;
  int                ready_from = 0, win_lo = -1, win_hi = -1, exp_issue = -1, exp_rsp = -1;
  logic              exp_we, exp_err;
  logic [ADDR_W-1:0] exp_addr;
  logic [3:0]        exp_be;
  logic [31:0]       exp_wd, exp_rdata;
  logic              exp_rdy;
  logic [ADDR_W-1:0] last_addr;
  logic [3:0]        last_be;
  logic [31:0]       last_wd;
  logic              last_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (avm_chipselect) begin
      last_addr = avm_address;
      last_be   = avm_byteenable;
      last_wd   = avm_writedata;
      last_we   = avm_write;
    end
    if (chk_en) begin
      exp_rdy = (cyc >= ready_from) && !(cyc >= win_lo && cyc <= win_hi);
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("avm_chipselect", 32'(avm_chipselect), 32'(cyc == exp_issue));
      check("avm_write", 32'(avm_write), 32'((cyc == exp_issue) && exp_we));
      if (cyc == exp_issue) begin
        check("avm_address", 32'(avm_address), 32'(exp_addr));
        check("avm_byteenable", 32'(avm_byteenable), 32'(exp_be));
        if (exp_we) check("avm_writedata", avm_writedata, exp_wd);
      end
      check("rsp_valid", 32'(rsp_valid), 32'(cyc == exp_rsp));
      if (cyc == exp_rsp) begin
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_rdata", rsp_rdata, exp_rdata);
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic err, output int lat);
    longint ea;
    int     nb, ix, n, acc;
    logic   flt;
    logic [31:0] val;
    logic [3:0]  be;
    @(negedge clk);
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
    req_valid = 1'b1;
    ea  = longint'(addr) - longint'(BASE);
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    flt = (size == 2'd3) || (ea < 0) || ((ea / 4) >= (64'd1 << ADDR_W));
`ifdef RISAC_LSU_MISALIGN_TRAP_EN
    if (size != 2'd3 && (ea % nb) != 0) flt = 1'b1;
`endif
    ea  = ea - (ea % nb);
    be  = 4'b0000;
    val = 32'd0;
    if (!flt) begin
      for (int i = 0; i < nb; i++) begin
        ix = int'(ea) + i;
        be = be | (4'b0001 << (ix % 4));
        if (we) ref_mem[ix] = wd[8*i +: 8];
        else    val = val | (32'(ref_mem[ix]) << (8*i));
      end
      if (!we && !uns && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
      if (we) val = 32'd0;
    end
    n = 0;
    while (req_ready !== 1'b1) begin
      if (n == 50) begin
        check("req_ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b0; rdata = 32'd0; err = 1'b0; lat = 0;
        return;
      end
      @(negedge clk);
      n++;
    end
    acc       = cyc + 1;
    exp_issue = flt ? -1 : acc;
    exp_rsp   = acc + (flt ? 0 : (we ? 1 : 1 + RL));
    win_lo    = acc;
    win_hi    = exp_rsp;
    exp_we    = we;
    exp_addr  = ADDR_W'(ea >> 2);
    exp_be    = be;
    exp_wd    = (size == 2'd0) ? {4{wd[7:0]}} : (size == 2'd1) ? {2{wd[15:0]}} : wd;
    exp_err   = flt;
    exp_rdata = val;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (rsp_valid !== 1'b1) check("rsp_timeout", 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
  endtask

  task automatic reset_mid(input int at_c);
    int n;
    chk_en = 1'b0;
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h4; req_size = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("rst_pre_ready", 32'(req_ready), 32'd1);
    repeat (at_c) @(negedge clk);
    check("rst_cs_before", 32'(avm_chipselect), 32'(at_c == 1));
    reset = 1'b1;
    #1;
    check("rst_cs_async", 32'(avm_chipselect), 32'd0);
    check("rst_rsp_async", 32'(rsp_valid), 32'd0);
    check("rst_ready_async", 32'(req_ready), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_rsp", 32'(rsp_valid), 32'd0);
      check("rst_hold_ready", 32'(req_ready), 32'd0);
      check("rst_hold_cs", 32'(avm_chipselect), 32'd0);
    end
    reset = 1'b0;
    #1;
    check("rst_ready_release", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rst_ready_first_edge", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_reissue_cs", 32'(avm_chipselect), 32'd1);
    n = 1;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("rst_reissue_lat", 32'(n), 32'd3);
    check("rst_reissue_rdata", rsp_rdata, 32'h80FF_1234);
    check("rst_reissue_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    exp_issue = -1; exp_rsp = -1; win_lo = -1; win_hi = -1; ready_from = 0;
    chk_en = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_cs", 32'(avm_chipselect), 32'd0);
    check("reset_write", 32'(avm_write), 32'd0);
    check("reset_be", 32'(avm_byteenable), 32'd0);
    check("reset_address", 32'(avm_address), 32'd0);
    check("reset_writedata", avm_writedata, 32'd0);
    reset = 1'b0;
    ready_from = cyc + 1;
    chk_en = 1'b1;

    do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF, rd, er, lat);
    check("t1_lat", 32'(lat), 32'd2);
    check("t1_err", 32'(er), 32'd0);
    check("t1_addr", 32'(last_addr), 32'd4);
    check("t1_be", 32'(last_be), 32'hF);
    check("t1_wd", last_wd, 32'hDEAD_BEEF);
    check("t1_we", 32'(last_we), 32'd1);

    do_req(1'b1, 32'h04, 2'd2, 1'b0, 32'h80FF_1234, rd, er, lat);
    do_req(1'b0, 32'h07, 2'd0, 1'b0, 32'd0, rd, er, lat);
    check("t2_be", 32'(last_be), 32'h8);
    check("t2_signed", rd, 32'hFFFF_FF80);
    check("t2_lat", 32'(lat), 32'd3);
    do_req(1'b0, 32'h07, 2'd0, 1'b1, 32'd0, rd, er, lat);
    check("t2_unsigned", rd, 32'h0000_0080);
    check("t2u_lat", 32'(lat), 32'd3);

    do_req(1'b1, 32'h22, 2'd1, 1'b0, 32'h0000_ABCD, rd, er, lat);
    check("t3_be", 32'(last_be), 32'hC);
    check("t3_wd", last_wd, 32'hABCD_ABCD);
    do_req(1'b0, 32'h22, 2'd1, 1'b1, 32'd0, rd, er, lat);
    check("t3_uhalf", rd, 32'h0000_ABCD);
    do_req(1'b0, 32'h22, 2'd1, 1'b0, 32'd0, rd, er, lat);
    check("t3_shalf", rd, 32'hFFFF_ABCD);

    do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, rd, er, lat);
    check("word_load", rd, 32'hDEAD_BEEF);
    do_req(1'b0, 32'h11, 2'd0, 1'b0, 32'd0, rd, er, lat);
    check("byte1_load", rd, 32'hFFFF_FFBE);
    do_req(1'b1, 32'h13, 2'd0, 1'b0, 32'h0000_005A, rd, er, lat);
    check("byte3_wd", last_wd, 32'h5A5A_5A5A);
    do_req(1'b0, 32'h10, 2'd2, 1'b1, 32'd0, rd, er, lat);
    check("merged_word", rd, 32'h5AAD_BEEF);

    do_req(1'b1, 32'hFFC, 2'd2, 1'b0, 32'h1234_5678, rd, er, lat);
    check("top_addr", 32'(last_addr), 32'h3FF);
    do_req(1'b0, 32'hFFC, 2'd2, 1'b0, 32'd0, rd, er, lat);
    check("top_load", rd, 32'h1234_5678);

    do_req(1'b0, 32'h1000, 2'd2, 1'b0, 32'd0, rd, er, lat);
    check("t4_range_err", 32'(er), 32'd1);
    check("t4_range_lat", 32'(lat), 32'd1);
    check("t4_range_rdata", rd, 32'd0);
    do_req(1'b0, 32'h04, 2'd3, 1'b0, 32'd0, rd, er, lat);
    check("t4_size_err", 32'(er), 32'd1);
    check("t4_size_lat", 32'(lat), 32'd1);
    do_req(1'b1, 32'hFFFF_FFF0, 2'd0, 1'b0, 32'h11, rd, er, lat);
    check("t4_store_err", 32'(er), 32'd1);

    do_req(1'b0, 32'h06, 2'd2, 1'b0, 32'd0, rd, er, lat);
`ifdef RISAC_LSU_MISALIGN_TRAP_EN
    check("t5_err", 32'(er), 32'd1);
    check("t5_lat", 32'(lat), 32'd1);
`else
    check("t5_err", 32'(er), 32'd0);
    check("t5_addr", 32'(last_addr), 32'd1);
    check("t5_rdata", rd, 32'h80FF_1234);
    check("t5_lat", 32'(lat), 32'd3);
`endif
    do_req(1'b0, 32'h23, 2'd1, 1'b1, 32'd0, rd, er, lat);
`ifdef RISAC_LSU_MISALIGN_TRAP_EN
    check("t5_half_err", 32'(er), 32'd1);
`else
    check("t5_half_rdata", rd, 32'h0000_ABCD);
`endif

    reset_mid(2);
    reset_mid(1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/risac_lsu_avalon.md
Name: risac_lsu_avalon

Overview:
- Load/store unit sitting directly upstream of the SoC's single-port on-chip data memory (Avalon-MM slave, 32-bit data, word address, byteenable, 1-cycle read latency).
- Accepts one RV32 load/store request at a time from the core's memory stage.
- Issues a single Avalon-MM access, then returns an aligned, sign- or zero-extended load result or a write completion.
- Flags access faults.

Parameters:
- ADDR_W, 10: word-address width of the target memory.
- BASE_ADDR, 32'h0000_0000: byte base address of the memory window; must be 4-byte aligned.
- READ_LATENCY, 1: cycles from the issue cycle to the readdata sample cycle; legal range 1..3.

Ports:
- clk  in  1: clock.
- reset  in  1: asynchronous, active-high reset.
- req_valid  in  1: request present.
- req_ready  out  1: request accepted when req_valid & req_ready.
- req_we  in  1: 1 = store, 0 = load.
- req_addr  in  32: byte address.
- req_size  in  2: 0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  in  1: loads only; zero-extend instead of sign-extend.
- req_wdata  in  32: store data, LSB-justified.
- rsp_valid  out  1: one-cycle completion pulse; no backpressure.
- rsp_rdata  out  32: load result; 0 for stores and faults.
- rsp_err  out  1: access fault; qualified by rsp_valid.
- avm_address  out  ADDR_W: word address.
- avm_byteenable  out  4: byte lanes.
- avm_chipselect  out  1: access strobe.
- avm_write  out  1: write strobe.
- avm_writedata  out  32: lane-replicated store data.
- avm_readdata  in  32: read data from memory.

Behaviour:
- Reset: state IDLE. All outputs 0, including req_ready. req_ready rises on the first clk edge after reset deasserts.
- States: IDLE, ISSUE, WAIT, RESP.
  - IDLE: req_ready = 1. On acceptance, register the request and run the checks. Fault → RESP. Otherwise → ISSUE.
  - ISSUE: exactly one cycle.
    - avm_chipselect = 1; avm_write = req_we.
    - avm_address = (req_addr - BASE_ADDR) >> 2.
    - Store → RESP. Load → WAIT.
  - WAIT: lasts READ_LATENCY cycles with all avm strobes at 0. avm_readdata is captured on the last WAIT cycle, then → RESP.
  - RESP: rsp_valid = 1 for one cycle, then → IDLE.
- req_ready = 0 in every state except IDLE. Back-to-back requests therefore see a 1-cycle gap after each response.
- Latency counted from the acceptance edge:
  - store: rsp_valid in cycle 2.
  - load: rsp_valid in cycle 2 + READ_LATENCY (cycle 3 at default).
  - fault: rsp_valid in cycle 1.
- Faults (rsp_err = 1, no bus access):
  - req_size = 3;
  - req_addr < BASE_ADDR;
  - (req_addr - BASE_ADDR) >> 2 ≥ 2^ADDR_W.
- Byteenable, with off = req_addr[1:0]:
  - byte: 4'b0001 << off.
  - half: 4'b0011 << {off[1], 1'b0}.
  - word: 4'b1111.
- Writedata:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load extract: readdata >> (8 × effective offset), truncated to the access size, then extended per req_unsigned. Word loads ignore req_unsigned.
- Avm outputs and rsp outputs are registered; no combinational path from req_* to avm_*.
- Reset mid-operation aborts the access: avm_chipselect drops asynchronously and no rsp_valid is produced.

Optional Feature:
- Macro: RISAC_LSU_MISALIGN_TRAP_EN.
- Defined: half access with addr[0] ≠ 0, or word access with addr[1:0] ≠ 0, is a fault. rsp_err = 1, rsp_valid in cycle 1, no bus access.
- Undefined: misalignment is silently masked.
  - half: effective offset = {addr[1], 0}.
  - word: effective offset = 0.
  - The access proceeds normally with err = 0.

Decomposition:
- Package risac_lsu_pkg holds:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - state enum;
  - functions lsu_byteenable(size, off) and lsu_wdata(size, wdata).
- Sub-module risac_lsu_align: purely combinational load extract and sign/zero-extension, instantiated once on the captured readdata.

Test Plan:
1. Store word 0xDEADBEEF to 0x10 → one ISSUE cycle with avm_address = 4, byteenable = 4'b1111, writedata = 0xDEADBEEF, write = 1. rsp_valid in cycle 2, err = 0.
2. Memory word 1 = 0x80FF_1234. Signed byte load from 0x07 → byteenable = 4'b1000, rsp_rdata = 0xFFFFFF80. Same load with req_unsigned = 1 → 0x00000080. Both rsp_valid in cycle 3.
3. Half store 0xABCD to 0x22 → byteenable = 4'b1100, writedata = 0xABCDABCD. Then unsigned half load from 0x22 → 0x0000ABCD.
4. Word load from 0x1000 (ADDR_W = 10, BASE = 0), and separately req_size = 3 → avm_chipselect never asserted; rsp_err = 1 and rsp_valid in cycle 1.
5. Word load from 0x06:
   - with RISAC_LSU_MISALIGN_TRAP_EN: rsp_err = 1 in cycle 1, no bus access;
   - without: avm_address = 1, full word returned, err = 0.
6. Assert reset during WAIT → chipselect 0 immediately, no rsp_valid. req_valid held high through the busy period is not accepted until req_ready returns after reset release.
